// File: rtl/riscv_nn_hwloop_regs_ext_if.sv
// rtl/riscv_nn_hwloop_regs_ext_if.sv - setup/decrement/readout bundle for the hwloop register file
interface riscv_nn_hwloop_regs_ext_if #(
  parameter int N_REGS     = 4,
  parameter int N_REG_BITS = $clog2(N_REGS),
  parameter int ADDR_W     = 32,
  parameter int CNT_W      = 32
);
  logic [ADDR_W-1:0]                 hwlp_start_data_i;
  logic [ADDR_W-1:0]                 hwlp_end_data_i;
  logic [CNT_W-1:0]                  hwlp_cnt_data_i;
  logic                              hwlp_reload_i;
  logic [2:0]                        hwlp_we_i;
  logic [N_REG_BITS-1:0]             hwlp_regid_i;
  logic                              valid_i;
  logic [N_REGS-1:0]                 hwlp_dec_cnt_i;
  logic                              hwlp_err_clr_i;
  logic [N_REGS-1:0][ADDR_W-1:0]     hwlp_start_addr_o;
  logic [N_REGS-1:0][ADDR_W-1:0]     hwlp_end_addr_o;
  logic [N_REGS-1:0][CNT_W-1:0]      hwlp_counter_o;
  logic [N_REGS-1:0]                 hwlp_active_o;
  logic [N_REGS-1:0]                 hwlp_done_o;
  logic                              hwlp_multi_dec_err_o;

  modport master (
    output hwlp_start_data_i, hwlp_end_data_i, hwlp_cnt_data_i, hwlp_reload_i,
           hwlp_we_i, hwlp_regid_i, valid_i, hwlp_dec_cnt_i, hwlp_err_clr_i,
    input  hwlp_start_addr_o, hwlp_end_addr_o, hwlp_counter_o, hwlp_active_o,
           hwlp_done_o, hwlp_multi_dec_err_o
  );

  modport slave (
    input  hwlp_start_data_i, hwlp_end_data_i, hwlp_cnt_data_i, hwlp_reload_i,
           hwlp_we_i, hwlp_regid_i, valid_i, hwlp_dec_cnt_i, hwlp_err_clr_i,
    output hwlp_start_addr_o, hwlp_end_addr_o, hwlp_counter_o, hwlp_active_o,
           hwlp_done_o, hwlp_multi_dec_err_o
  );
endinterface

// File: rtl/riscv_nn_hwloop_regs_ext.sv
// rtl/riscv_nn_hwloop_regs_ext.sv - hardware-loop start/end/counter registers with auto-reload and status
module riscv_nn_hwloop_regs_ext #(
  parameter int N_REGS     = 4,
  parameter int N_REG_BITS = $clog2(N_REGS),
  parameter int ADDR_W     = 32,
  parameter int CNT_W      = 32
) (
  input logic                      clk,
  input logic                      rst_n,
  riscv_nn_hwloop_regs_ext_if.slave bus
);

  logic [N_REGS-1:0][ADDR_W-1:0] start_q, start_d;
  logic [N_REGS-1:0][ADDR_W-1:0] end_q, end_d;
  logic [N_REGS-1:0][CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_REGS-1:0][CNT_W-1:0]  init_q, init_d;
  logic [N_REGS-1:0]             reload_q, reload_d;
  logic [N_REGS-1:0]             done_q, done_d;
  logic                          err_q, err_d;

  logic [N_REG_BITS-1:0] regid;
  logic [N_REGS-1:0]     dec_req;
  logic [N_REGS-1:0]     grant;
  logic                  grant_found;
  logic                  multi_dec;
  logic                  wr_ok;

  assign regid   = bus.hwlp_regid_i;
  assign dec_req = bus.valid_i ? bus.hwlp_dec_cnt_i : '0;

  always_comb begin
    start_d     = start_q;
    end_d       = end_q;
    cnt_d       = cnt_q;
    init_d      = init_q;
    reload_d    = reload_q;
    done_d      = '0;
    err_d       = err_q;
    grant       = '0;
    grant_found = 1'b0;
    wr_ok       = int'(regid) < N_REGS;
    // Clearing the lowest set bit leaves something only if two or more requests were raised.
    multi_dec   = |(dec_req & (dec_req - N_REGS'(1)));

    for (int k = 0; k < N_REGS; k++) begin
      if (dec_req[k] && !grant_found) begin
        grant[k]    = 1'b1;
        grant_found = 1'b1;
      end
    end

    for (int k = 0; k < N_REGS; k++) begin
      if (grant[k]) begin
        if (cnt_q[k] > CNT_W'(1)) begin
          cnt_d[k] = cnt_q[k] - CNT_W'(1);
        end else if (cnt_q[k] == CNT_W'(1)) begin
          done_d[k] = 1'b1;
          cnt_d[k]  = reload_q[k] ? init_q[k] : '0;
        end
      end
    end

    // Setup writes are applied last so they override a decrement of the same loop.
    if (wr_ok) begin
      if (bus.hwlp_we_i[0]) start_d[regid] = bus.hwlp_start_data_i;
      if (bus.hwlp_we_i[1]) end_d[regid]   = bus.hwlp_end_data_i;
      if (bus.hwlp_we_i[2]) begin
        cnt_d[regid]    = bus.hwlp_cnt_data_i;
        init_d[regid]   = bus.hwlp_cnt_data_i;
        reload_d[regid] = bus.hwlp_reload_i;
        done_d[regid]   = 1'b0;
      end
    end

    if (bus.hwlp_err_clr_i) err_d = 1'b0;
    if (multi_dec)          err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      start_q  <= '0;
      end_q    <= '0;
      cnt_q    <= '0;
      init_q   <= '0;
      reload_q <= '0;
      done_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      start_q  <= start_d;
      end_q    <= end_d;
      cnt_q    <= cnt_d;
      init_q   <= init_d;
      reload_q <= reload_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    bus.hwlp_active_o = '0;
    for (int k = 0; k < N_REGS; k++) begin
      bus.hwlp_active_o[k] = |cnt_q[k];
    end
  end

  assign bus.hwlp_start_addr_o    = start_q;
  assign bus.hwlp_end_addr_o      = end_q;
  assign bus.hwlp_counter_o       = cnt_q;
  assign bus.hwlp_done_o          = done_q;
  assign bus.hwlp_multi_dec_err_o = err_q;

endmodule
